// File: rtl/jtag_bridge_pkg.sv
// Shared command/response encodings and FSM state type for the USB-to-JTAG bridge.
package jtag_bridge_pkg;

  localparam logic [7:0] CMD_WRITE_BASE = 8'h30;
  localparam logic [7:0] CMD_READ       = 8'h52;
  localparam logic [7:0] CMD_RESET_BASE = 8'h72;
  localparam logic [7:0] CMD_LED_ON     = 8'h42;
  localparam logic [7:0] CMD_LED_OFF    = 8'h62;
  localparam logic [7:0] CMD_SEL_BASE   = 8'hA0;

  localparam logic [7:0] RESP_LOW       = 8'h30;
  localparam logic [7:0] RESP_HIGH      = 8'h31;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

  // Pin-write commands occupy 0x30..0x37: the top five bits match the base.
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return (cmd[7:3] == CMD_WRITE_BASE[7:3]);
  endfunction

endpackage

// File: rtl/jtag_bridge_mc_sync_fifo.sv
// Single-clock response FIFO; power-of-two depth so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s  = push_i && !full_o;
  assign pop_ok_s   = pop_i && !empty_o;
  assign empty_o    = (count_r == CNT_W'(0));
  assign full_o     = (count_r == CNT_W'(DEPTH));
  assign count_o    = count_r;
  assign pop_data_o = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data_i;
  end

endmodule

// File: rtl/jtag_bridge_mc.sv
// USB CDC byte-command to multi-target JTAG bit-bang bridge with buffered TDO responses.
module jtag_bridge_mc
  import jtag_bridge_pkg::*;
#(
  parameter int TARGETS    = 2,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int SEL_W     = (TARGETS > 1) ? $clog2(TARGETS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         from_usb_data_i,
  input  logic               from_usb_valid_i,
  output logic               from_usb_ready_o,
  output logic [7:0]         to_usb_data_o,
  output logic               to_usb_valid_o,
  input  logic               to_usb_ready_i,
  output logic [TARGETS-1:0] tck_o,
  output logic [TARGETS-1:0] tms_o,
  output logic [TARGETS-1:0] tdi_o,
  input  logic [TARGETS-1:0] tdo_i,
  output logic               trst_o,
  output logic               srst_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               bitbang_led_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state_r, state_nxt_s;
  logic [7:0]         hold_r, hold_nxt_s;
  logic               ready_r;
  logic [TARGETS-1:0] tck_r, tms_r, tdi_r;
  logic               trst_r, srst_r, led_r;
  logic [SEL_W-1:0]   sel_r;

  logic [7:0]         cmd_s;
  logic               accept_s, push_s, pop_s;
  logic               is_write_s, is_read_s, is_rst_s, is_sel_s;
  logic [7:0]         resp_s;
  logic               fifo_empty_s, fifo_full_s;
  logic [CNT_W-1:0]   fifo_count_s, count_nxt_s;
  logic               ready_nxt_s;

  assign cmd_s      = from_usb_data_i;
  assign accept_s   = from_usb_valid_i && ready_r;
  assign is_write_s = is_write_cmd(cmd_s);
  assign is_read_s  = (cmd_s == CMD_READ);
  assign is_rst_s   = (cmd_s >= CMD_RESET_BASE) && (cmd_s <= (CMD_RESET_BASE + 8'd3));
  assign is_sel_s   = (cmd_s[7:4] == CMD_SEL_BASE[7:4]) && (32'(cmd_s[3:0]) < TARGETS);
  // The only input-to-FIFO combinational path: TDO of the selected target.
  assign resp_s     = tdo_i[sel_r] ? RESP_HIGH : RESP_LOW;
  assign push_s     = accept_s && is_read_s;
  assign pop_s      = to_usb_valid_o && to_usb_ready_i;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (resp_s),
    .pop_i       (pop_s),
    .pop_data_o  (to_usb_data_o),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .count_o     (fifo_count_s)
  );

  assign to_usb_valid_o = !fifo_empty_s;

  // Next-state logic: pin writes hold off the next command for CLK_DIV cycles.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && is_write_s && (CLK_DIV > 1)) begin
          state_nxt_s = ST_HOLD;
          hold_nxt_s  = 8'(CLK_DIV - 1);
        end else begin
          state_nxt_s = ST_ACCEPT;
          hold_nxt_s  = 8'd0;
        end
      end
      ST_HOLD: begin
        if (hold_r <= 8'd1) begin
          state_nxt_s = ST_ACCEPT;
          hold_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = ST_HOLD;
          hold_nxt_s  = hold_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_ACCEPT;
        hold_nxt_s  = 8'd0;
      end
    endcase
  end

  // Ready is registered, so it is derived from next-cycle state and occupancy;
  // a pop while full therefore frees the slot only from the following cycle.
  assign count_nxt_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  assign ready_nxt_s = (state_nxt_s == ST_ACCEPT) && (count_nxt_s != CNT_W'(FIFO_DEPTH));

  // FSM state, hold counter and handshake ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_ACCEPT;
      hold_r  <= 8'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Command execution on the accepting edge; switching targets parks both old and new at idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_r  <= SEL_W'(0);
      tck_r  <= {TARGETS{1'b0}};
      tms_r  <= {TARGETS{1'b1}};
      tdi_r  <= {TARGETS{1'b0}};
      trst_r <= 1'b0;
      srst_r <= 1'b0;
      led_r  <= 1'b0;
    end else if (accept_s) begin
      if (is_write_s) begin
        tck_r[sel_r] <= cmd_s[2];
        tms_r[sel_r] <= cmd_s[1];
        tdi_r[sel_r] <= cmd_s[0];
      end else if (is_rst_s) begin
        {trst_r, srst_r} <= cmd_s[1:0] - 2'b10;
      end else if (cmd_s == CMD_LED_ON) begin
        led_r <= 1'b1;
      end else if (cmd_s == CMD_LED_OFF) begin
        led_r <= 1'b0;
      end else if (is_sel_s && (SEL_W'(cmd_s[3:0]) != sel_r)) begin
        sel_r <= SEL_W'(cmd_s[3:0]);
        tck_r <= {TARGETS{1'b0}};
        tms_r <= {TARGETS{1'b1}};
        tdi_r <= {TARGETS{1'b0}};
      end
    end
  end

  assign from_usb_ready_o = ready_r;
  assign tck_o            = tck_r;
  assign tms_o            = tms_r;
  assign tdi_o            = tdi_r;
  assign trst_o           = trst_r;
  assign srst_o           = srst_r;
  assign sel_o            = sel_r;
  assign bitbang_led_o    = led_r;

endmodule
